// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : piso_pkg
//  Brief    : Shared types and constants for the parallel-in serial-out stage.
//  Revision : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // Serializer control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Width of the inter-word gap counter (gap length 0..15)
    localparam int GAP_W = 4;

endpackage : piso_pkg
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Brief    : Accepts a parallel word over valid/ready and shifts it out one
//             bit per clock, with frame markers and an optional idle gap
//             after each word. Bit order suits a downstream right-shifting
//             SIPO that shifts in at its MSB.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    // Bit counter sized to hold WIDTH-1 (remaining bits after the first)
    localparam int                 c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam bit                 c_has_gap  = (GAP_CYCLES > 0);
    localparam logic [GAP_W-1:0]   c_gap_load = c_has_gap ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [GAP_W-1:0]   r_gcnt;

    logic               w_accept;
    logic               w_first_bit;
    logic [WIDTH-1:0]   w_load_shreg;
    logic               w_next_bit;
    logic [WIDTH-1:0]   w_shifted;

    // Bit-order selection: the shift register always moves toward the output end
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_first_bit  = par_data[0];
            assign w_load_shreg = par_data >> 1;
            assign w_next_bit   = r_shreg[0];
            assign w_shifted    = r_shreg >> 1;
        end else begin : g_msb_first
            assign w_first_bit  = par_data[WIDTH-1];
            assign w_load_shreg = par_data << 1;
            assign w_next_bit   = r_shreg[WIDTH-1];
            assign w_shifted    = r_shreg << 1;
        end
    endgenerate

    // Ready in idle, or on the last bit when no gap is configured so words can
    // follow back-to-back without a bubble
    assign par_ready = (r_state == S_IDLE) ||
                       ((r_state == S_SHIFT) && (r_cnt == '0) && !c_has_gap);
    assign w_accept  = par_valid && par_ready;
    assign busy      = (r_state != S_IDLE);

    // Control FSM with registered serial outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= w_load_shreg;
                        r_cnt     <= c_cnt_load;
                        ser_out   <= w_first_bit;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        // Present the next bit; the last one carries the frame marker
                        ser_out  <= w_next_bit;
                        ser_last <= (r_cnt == c_cnt_one);
                        r_shreg  <= w_shifted;
                        r_cnt    <= r_cnt - c_cnt_one;
                    end else if (w_accept) begin
                        // Back-to-back word: reload without leaving the shift state
                        r_shreg   <= w_load_shreg;
                        r_cnt     <= c_cnt_load;
                        ser_out   <= w_first_bit;
                        ser_valid <= 1'b1;
                        ser_last  <= 1'b0;
                    end else begin
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_last  <= 1'b0;
                        if (c_has_gap) begin
                            r_gcnt  <= c_gap_load;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_GAP: begin
                    if (r_gcnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt - GAP_W'(1);
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    ser_out   <= 1'b0;
                    ser_valid <= 1'b0;
                    ser_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule : piso_serializer
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Brief    : Directed self-checking bench for piso_serializer. Three instances
//             cover LSB-first/no-gap, LSB-first/2-cycle gap and MSB-first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic       clk;
    logic       reset_n;

    logic [3:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, b_ready, c_ready;
    logic       a_out, b_out, c_out;
    logic       a_sv, b_sv, c_sv;
    logic       a_last, b_last, c_last;
    logic       a_busy, b_busy, c_busy;

    // Observation vectors: {busy, par_ready, ser_valid, ser_last, ser_out}
    logic [4:0] va, vb, vc;
    assign va = {a_busy, a_ready, a_sv, a_last, a_out};
    assign vb = {b_busy, b_ready, b_sv, b_last, b_out};
    assign vc = {c_busy, c_ready, c_sv, c_last, c_out};

    int checks = 0;
    int errors = 0;

    // Downstream 4-bit SIPO: shifts in at MSB, shifts right
    logic [3:0] sipo;
    always @(posedge clk) begin
        if (a_sv) sipo <= {a_out, sipo[3:1]};
    end

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .par_data(a_data), .par_valid(a_valid),
        .par_ready(a_ready), .ser_out(a_out), .ser_valid(a_sv),
        .ser_last(a_last), .busy(a_busy));

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .par_data(b_data), .par_valid(b_valid),
        .par_ready(b_ready), .ser_out(b_out), .ser_valid(b_sv),
        .ser_last(b_last), .busy(b_busy));

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .reset_n(reset_n), .par_data(c_data), .par_valid(c_valid),
        .par_ready(c_ready), .ser_out(c_out), .ser_valid(c_sv),
        .ser_last(c_last), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_data = '0; b_data = '0; c_data = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;

        // Reset state
        #12;
        chk("rst_a", va & 5'b10111, 5'b00000);
        chk("rst_b", vb & 5'b10111, 5'b00000);
        chk("rst_c", vc & 5'b10111, 5'b00000);
        reset_n = 1'b1;
        tick();
        chk("idle_a", va, 5'b01000);
        chk("idle_b", vb, 5'b01000);
        chk("idle_c", vc, 5'b01000);

        // Single word 1011, LSB first: 1,1,0,1
        a_data = 4'b1011; a_valid = 1'b1;
        tick(); a_valid = 1'b0;
        chk("w1_b0", va, 5'b10101);
        tick(); chk("w1_b1", va, 5'b10101);
        tick(); chk("w1_b2", va, 5'b10100);
        tick(); chk("w1_b3", va, 5'b11111);
        tick(); chk("w1_end", va, 5'b01000);
        chk("w1_sipo", {1'b0, sipo}, 5'b01011);

        // Back-to-back 1011 then 0110 with valid held
        a_data = 4'b1011; a_valid = 1'b1;
        tick(); a_data = 4'b0110;
        chk("bb_b0", va, 5'b10101);
        tick(); chk("bb_b1", va, 5'b10101);
        tick(); chk("bb_b2", va, 5'b10100);
        tick(); chk("bb_b3", va, 5'b11111);
        tick(); a_valid = 1'b0;
        chk("bb_b4", va, 5'b10100);
        tick(); chk("bb_b5", va, 5'b10101);
        tick(); chk("bb_b6", va, 5'b10101);
        tick(); chk("bb_b7", va, 5'b11110);
        tick(); chk("bb_end", va, 5'b01000);
        chk("bb_sipo", {1'b0, sipo}, 5'b00110);

        // Gap of 2 with valid held and data toggling while not ready
        b_data = 4'b1011; b_valid = 1'b1;
        tick(); b_data = 4'b0100;
        chk("gp_b0", vb, 5'b10101);
        tick(); b_data = 4'b1111;
        chk("gp_b1", vb, 5'b10101);
        tick(); b_data = 4'b0000;
        chk("gp_b2", vb, 5'b10100);
        tick(); b_data = 4'b1010;
        chk("gp_b3", vb, 5'b10111);
        tick(); b_data = 4'b0101;
        chk("gp_g0", vb, 5'b10000);
        tick(); b_data = 4'b0110;
        chk("gp_g1", vb, 5'b10000);
        tick(); chk("gp_idle", vb, 5'b01000);
        tick(); b_valid = 1'b0;
        chk("gp2_b0", vb, 5'b10100);
        tick(); chk("gp2_b1", vb, 5'b10101);
        tick(); chk("gp2_b2", vb, 5'b10101);
        tick(); chk("gp2_b3", vb, 5'b10110);
        tick(); chk("gp2_g0", vb, 5'b10000);
        tick(); chk("gp2_g1", vb, 5'b10000);
        tick(); chk("gp2_idle", vb, 5'b01000);

        // Mid-word reset after two bits, then a fresh word 0001
        a_data = 4'b1011; a_valid = 1'b1;
        tick(); a_valid = 1'b0;
        chk("mr_b0", va, 5'b10101);
        tick(); chk("mr_b1", va, 5'b10101);
        reset_n = 1'b0;
        #2 chk("mr_clear", va & 5'b10111, 5'b00000);
        #2 reset_n = 1'b1;
        #1 chk("mr_ready", va, 5'b01000);
        a_data = 4'b0001; a_valid = 1'b1;
        tick(); a_valid = 1'b0;
        chk("fr_b0", va, 5'b10101);
        tick(); chk("fr_b1", va, 5'b10100);
        tick(); chk("fr_b2", va, 5'b10100);
        tick(); chk("fr_b3", va, 5'b11110);
        tick(); chk("fr_end", va, 5'b01000);
        chk("fr_sipo", {1'b0, sipo}, 5'b00001);

        // MSB first: 1000 -> 1,0,0,0
        c_data = 4'b1000; c_valid = 1'b1;
        tick(); c_valid = 1'b0;
        chk("msb_b0", vc, 5'b10101);
        tick(); chk("msb_b1", vc, 5'b10100);
        tick(); chk("msb_b2", vc, 5'b10100);
        tick(); chk("msb_b3", vc, 5'b11110);
        tick(); chk("msb_end", vc, 5'b01000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_piso_serializer
`default_nettype wire
